// File: rtl/lcd_hex_writer_if.sv
// Strobe/byte/done bundle between lcd_hex_writer and the downstream i2c_master.
// The "master" modport is the writer side, the "slave" modport is the i2c_master side.
interface lcd_hex_writer_if;
  logic       i2c_write;
  logic       i2c_send;
  logic       i2c_start;
  logic       i2c_end;
  logic [7:0] i2c_byte;
  logic       i2c_done;

  modport master (
    output i2c_write, i2c_send, i2c_start, i2c_end, i2c_byte,
    input  i2c_done
  );

  modport slave (
    input  i2c_write, i2c_send, i2c_start, i2c_end, i2c_byte,
    output i2c_done
  );
endinterface

// File: rtl/lcd_hex_writer.sv
// Writes a 16-bit value to an I2C character LCD as 4 uppercase hex digits, one i2c_master op at a time.
// Optional feature macro LCD_LABEL_EN: prefix the digits with the two LABEL characters.
module lcd_hex_writer #(
  parameter logic [7:0]  LCD_ADDR    = 8'h7c,
  parameter logic [6:0]  CURSOR_POS  = 7'h00,
  parameter int unsigned GUARD_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [15:0] LABEL       = 16'h583d
) (
  input  logic             clk,
  input  logic             res,
  input  logic             init_done,
  input  logic             update,
  input  logic [15:0]      value,
  output logic             busy,
  output logic             err,
  lcd_hex_writer_if.master bus
);

`ifdef LCD_LABEL_EN
  localparam int N_LABEL = 2;
`else
  localparam int N_LABEL = 0;
`endif
  // Steps: 0 START, 1 addr, 2 8'h80, 3 cursor, 4 END, 5 START, 6 addr, 7 8'h40, 8.. data, last END.
  localparam logic [3:0] LAST_STEP = 4'(12 + N_LABEL);

  typedef enum logic [1:0] {OP_START, OP_END, OP_BYTE} op_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;

  state_t      state;
  logic [3:0]  step;
  logic        pending;
  logic [15:0] pend_val;
  logic [15:0] cur_val;
  logic        issue_send;
  logic [7:0]  guard_cnt;
  logic [15:0] wait_cnt;

  logic [3:0]  nxt_step;
  logic [2:0]  data_idx;
  logic [7:0]  chars [8];
  op_t         nxt_op;
  logic [7:0]  nxt_byte;
  logic        start_seq;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign nxt_step  = step + 4'd1;
  // Without a label the data index starts at 2, skipping the two label slots.
  assign data_idx  = 3'(nxt_step - 4'd6 - 4'(N_LABEL));
  assign start_seq = (state == S_IDLE) && (pending || update) && init_done;

  always_comb begin
    chars[0] = LABEL[15:8];
    chars[1] = LABEL[7:0];
    chars[2] = hex_char(cur_val[15:12]);
    chars[3] = hex_char(cur_val[11:8]);
    chars[4] = hex_char(cur_val[7:4]);
    chars[5] = hex_char(cur_val[3:0]);
    chars[6] = 8'h00;
    chars[7] = 8'h00;
  end

  // Decode of the step that follows the current one; only consulted when leaving WAIT.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    nxt_op   = OP_BYTE;
    nxt_byte = 8'h00;
    if (nxt_step == 4'd5)
      nxt_op = OP_START;
    else if (nxt_step == 4'd4 || nxt_step == LAST_STEP)
      nxt_op = OP_END;
    else if (nxt_step == 4'd1 || nxt_step == 4'd6)
      nxt_byte = LCD_ADDR;
    else if (nxt_step == 4'd2)
      nxt_byte = 8'h80;
    else if (nxt_step == 4'd3)
      nxt_byte = {1'b1, CURSOR_POS};
    else if (nxt_step == 4'd7)
      nxt_byte = 8'h40;
    else
      nxt_byte = chars[data_idx];
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state         <= S_IDLE;
      step          <= 4'd0;
      pending       <= 1'b0;
      pend_val      <= 16'h0000;
      cur_val       <= 16'h0000;
      issue_send    <= 1'b0;
      guard_cnt     <= 8'd0;
      wait_cnt      <= 16'd0;
      busy          <= 1'b0;
      err           <= 1'b0;
      bus.i2c_write <= 1'b0;
      bus.i2c_send  <= 1'b0;
      bus.i2c_start <= 1'b0;
      bus.i2c_end   <= 1'b0;
      bus.i2c_byte  <= 8'h00;
    end else begin
      // NOTE: non-blocking throughout; strobes default low so each lasts exactly one cycle.
      bus.i2c_write <= 1'b0;
      bus.i2c_send  <= 1'b0;
      bus.i2c_start <= 1'b0;
      bus.i2c_end   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start_seq) begin
            cur_val       <= update ? value : pend_val;
            pending       <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b1;
            step          <= 4'd0;
            bus.i2c_start <= 1'b1;
            issue_send    <= 1'b0;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (issue_send) begin
            bus.i2c_send <= 1'b1;
            issue_send   <= 1'b0;
          end else begin
            guard_cnt <= 8'd0;
            state     <= S_GUARD;
          end
        end

        // The master's done still reflects the previous op for a cycle after a strobe.
        S_GUARD: begin
          if (guard_cnt == 8'(GUARD_CYC - 1)) begin
            wait_cnt <= 16'd0;
            state    <= S_WAIT;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end

        S_WAIT: begin
          if (bus.i2c_done) begin
            if (step == LAST_STEP) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              step  <= nxt_step;
              state <= S_ISSUE;
              case (nxt_op)
                OP_START: bus.i2c_start <= 1'b1;
                OP_END:   bus.i2c_end   <= 1'b1;
                default: begin
                  bus.i2c_write <= 1'b1;
                  bus.i2c_byte  <= nxt_byte;
                  issue_send    <= 1'b1;
                end
              endcase
            end
          end else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            pending <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Placed after the FSM so an update always lands in the buffer, even on a timeout cycle.
      if (update && !start_seq) begin
        pend_val <= value;
        pending  <= 1'b1;
      end
    end
  end

endmodule
